// File: rtl/mux_stream_rr.sv
// -----------------------------------------------------------------------------
// mux_stream_rr
//
// N-channel registered stream multiplexer. Each cycle one input channel is
// granted, either by an explicit index (mode=0) or by round-robin arbitration
// among the valid channels (mode=1). The granted word is captured into a
// single output register that drains through a valid/ready handshake.
//
// Handshake: a word moves on a channel when valid and ready are both high at a
// rising edge. Ready never depends on the same channel's valid being
// registered. A producer may raise valid at any time and must hold its word
// until it sees ready. The consumer side may drop out_ready at any time. While
// out_valid=1 and out_ready=0 the output word is frozen.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used when mode=0
//   in_data    packed input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit set (combinational)
//   out_data   registered output word
//   out_chan   channel index that out_data came from
//   out_valid  output register holds a word
//   out_ready  consumer accepts out_data this cycle
// -----------------------------------------------------------------------------
module mux_stream_rr #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic             load_en;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;

   // The register can take a new word when empty or drained this same cycle.
   assign load_en = !out_valid_q || out_ready;

   // Grant selection. In round-robin mode the loop runs from the farthest
   // candidate back to ptr so the last hit written is the first valid channel
   // at or after ptr in circular order. An out-of-range sel never matches.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      if (!mode) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_W'(i);
            end
         end
      end else begin
         for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (in_valid[(int'(ptr_q) + k) % CHANNELS]) begin
               grant_vld = 1'b1;
               grant_idx = SEL_W'((int'(ptr_q) + k) % CHANNELS);
            end
         end
      end
   end

   // Data mux with constant slice bases; only the granted channel reaches the
   // register, so X on any other channel cannot leak to the outputs.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Ready is held low during reset: the register cannot capture then, and a
   // high ready would tell a producer its word was taken when it was dropped.
   always_comb begin
      in_ready = '0;
      if (rst_n && load_en && grant_vld) begin
         in_ready = CHANNELS'(1) << grant_idx;
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load_en) begin
         if (grant_vld) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            // Pointer only moves on round-robin transfers so a stretch in
            // fixed mode does not disturb fairness when round-robin resumes.
            if (mode) begin
               ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/mux_stream_rr.md
# mux_stream_rr

Parametrised N-channel registered stream multiplexer: the successor to our plain 2:1 combinational data mux. It selects one of CHANNELS input streams, either by an explicit select or by round-robin arbitration among the valid inputs. The chosen word passes through a single output register with a valid/ready handshake. It sits between multiple producer stages and one shared consumer.

## Interface
Parameters:
- WIDTH, 8, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- SEL_W, $clog2(CHANNELS), width of the select and channel-tag fields (derived; do not override)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- in_data  input  CHANNELS*WIDTH  packed input words; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit set per cycle
- out_data  output  WIDTH  registered output word
- out_chan  output  SEL_W  index of the channel that out_data came from
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Reset is asynchronous and active-low; one clock, no other clock domains.
- Reset values: out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. in_ready is combinational; it is 0 while out_valid=0 only if no channel is granted.
- load_en = !out_valid || out_ready. The output register can accept a new word when it is empty or is being drained in the same cycle.
- Grant g, combinational:
  - mode=0: g=sel if sel<CHANNELS and in_valid[sel]=1; otherwise there is no grant. If sel>=CHANNELS, no channel is ever granted.
  - mode=1: g is the first i with in_valid[i]=1, searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1. There is no grant if in_valid is all zero.
- in_ready[i] = load_en && grant exists && (i==g). All other bits are 0.
- Transfer: when in_ready[g] is set, then at the next edge out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- If load_en=1 and there is no grant, out_valid <= 0 at the next edge. out_data and out_chan hold their last values.
- If out_valid=1 and out_ready=0, out_data, out_chan and out_valid hold stable, and every in_ready bit is 0 (no drops, no overwrite).
- ptr updates only on a transfer while mode=1: ptr <= (g==CHANNELS-1) ? 0 : g+1. In mode=0 ptr holds its value, so switching back to round-robin resumes fairly.
- mode and sel are sampled combinationally each cycle. A change affects the grant in the same cycle and never corrupts a word already in the output register.
- in_data of non-granted channels is ignored. X on a non-granted channel must not propagate to the outputs.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on out_data/out_valid after edge N.
- Throughput is 1 word/cycle with out_ready held high: a simultaneous drain and load at the same edge is legal and required.
- Round-robin fairness: with all CHANNELS valid continuously and out_ready=1, grants cycle 0,1,...,CHANNELS-1,0,... with no repeats.
- No combinational path from in_valid or in_data to out_data, out_valid or out_chan.
- Combinational paths that do exist: out_ready to in_ready, and in_valid/mode/sel/ptr to in_ready.
- Reset asserted mid-transfer: the outputs clear immediately (asynchronously) and ptr=0. After rst_n deasserts, the first grant follows the normal rules.

## Test plan
- Reset: drive rst_n=0 while all valids=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0. Release with in_valid=4'b0000 -> out_valid stays 0.
- Fixed mode, WIDTH=8, CHANNELS=4: mode=0, sel=2, in_data ch2=0xA5, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xA5, out_chan=2, out_valid=1.
- Round-robin: mode=1, all valid, ch i data=0x10+i, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1 with matching data 0x10..0x13, 0x10, 0x11.
- Backpressure: while out_valid=1 with out_chan=1, drop out_ready for 3 cycles -> out_data/out_chan constant and in_ready=0. Raise out_ready -> ch2 is accepted the same cycle.
- Sparse round-robin with wrap: ptr=3, in_valid=4'b0010 -> g=1, then ptr=2. Next, in_valid=4'b0001 -> g=0, then ptr=1.
- Illegal select and mode switch: mode=0, sel=3 with CHANNELS=3 -> in_ready=0, out_valid drops after draining. Switch to mode=1 -> grants resume from the preserved ptr.
